// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers and constants for the streaming KxK
// convolution datapath.
package conv_pkg;

    localparam int LAT = 3;

    // Ceiling log2, never below 1 so it can size a port.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_bit(input int d, input int w, input int k);
        return d + w + 1 + clog2(k * k);
    endfunction

    // Optional ReLU, then clamp to the signed range of ob bits.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 ob,
        input logic               relu
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] x;
        hi = (64'sd1 <<< (ob - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ob - 1));
        x  = (relu && v < 0) ? 64'sd0 : v;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/conv_linebuf_k.sv
// conv_linebuf_k: raster counters with sof resync, K-1 line buffers
// and the KxK window register; flags complete windows.
module conv_linebuf_k
    import conv_pkg::*;
#(
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int DATA_BIT = 8,
    parameter int K        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_BIT-1:0]       in_data,
    output logic [K*K*DATA_BIT-1:0]   window,
    output logic                      window_valid,
    output logic                      last_window
);
    localparam int CW = clog2(WIDTH);
    localparam int RW = clog2(HEIGHT);

    logic [CW-1:0] col, col_eff;
    logic [RW-1:0] row, row_eff;
    logic [K-2:0][WIDTH-1:0][DATA_BIT-1:0] lb;
    logic [K-1:0][K-1:0][DATA_BIT-1:0]     win;
    logic [K-1:0][DATA_BIT-1:0]            col_vec;

    // Position of the pixel being accepted; sof forces (0,0).
    always_comb begin
        col_eff = in_sof ? '0 : col;
        row_eff = in_sof ? '0 : row;
        col_vec = '0;
        col_vec[K-1] = in_data;
        for (int l = 0; l < K - 1; l++) begin
            col_vec[K-2-l] = lb[l][WIDTH-1];
        end
    end

    assign window = win;

    // Counters, line buffers and window all advance on accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            lb           <= '0;
            win          <= '0;
            window_valid <= 1'b0;
            last_window  <= 1'b0;
        end else begin
            window_valid <= in_valid
                         && row_eff >= RW'(K - 1)
                         && col_eff >= CW'(K - 1);
            last_window  <= in_valid
                         && row_eff == RW'(HEIGHT - 1)
                         && col_eff == CW'(WIDTH - 1);
            if (in_valid) begin
                if (col_eff == CW'(WIDTH - 1)) begin
                    col <= '0;
                    row <= (row_eff == RW'(HEIGHT - 1))
                         ? '0 : row_eff + 1'b1;
                end else begin
                    col <= col_eff + 1'b1;
                    row <= row_eff;
                end
                lb[0] <= {lb[0][WIDTH-2:0], in_data};
                for (int l = 1; l < K - 1; l++) begin
                    lb[l] <= {lb[l][WIDTH-2:0], lb[l-1][WIDTH-1]};
                end
                for (int r = 0; r < K; r++) begin
                    win[r] <= {col_vec[r], win[r][K-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming KxK convolution with runtime weights,
// 3-stage MAC pipeline, shift / ReLU / saturate per channel.
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int DATA_BIT = 8,
    parameter int K        = 5,
    parameter int OUT_CH   = 3,
    parameter int W_BIT    = 8,
    parameter int OUT_BIT  = 12,
    parameter int SHIFT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [DATA_BIT-1:0]         in_data,
    input  logic                        w_we,
    input  logic [clog2(OUT_CH)-1:0]    w_ch,
    input  logic [clog2(K*K)-1:0]       w_idx,
    input  logic [W_BIT-1:0]            w_data,
    input  logic                        relu_en,
    output logic [OUT_CH*OUT_BIT-1:0]   conv_out,
    output logic                        out_valid,
    output logic                        frame_done
);
    localparam int KK      = K * K;
    localparam int PB      = DATA_BIT + W_BIT + 1;
    localparam int ACC_BIT = acc_bit(DATA_BIT, W_BIT, K);

    logic [KK*DATA_BIT-1:0]    window;
    logic                      win_valid, last_win, relu_w;
    logic [LAT-1:0]            vpipe, lpipe, rpipe;
    logic signed [W_BIT-1:0]   wt [OUT_CH][KK];
    logic signed [PB-1:0]      prod [OUT_CH][KK];
    logic signed [ACC_BIT-1:0] rs_nx [OUT_CH][K];
    logic signed [ACC_BIT-1:0] rs [OUT_CH][K];
    logic signed [ACC_BIT-1:0] tot, sh;
    logic [OUT_CH*OUT_BIT-1:0] out_nx;

    conv_linebuf_k #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .DATA_BIT (DATA_BIT),
        .K        (K)
    ) u_linebuf (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .window       (window),
        .window_valid (win_valid),
        .last_window  (last_win)
    );

    assign out_valid  = vpipe[LAT-1];
    assign frame_done = lpipe[LAT-1];

    // Weight file; out-of-range channel or tap writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < OUT_CH; c++)
                for (int t = 0; t < KK; t++)
                    wt[c][t] <= '0;
        end else if (w_we && int'(w_ch) < OUT_CH
                     && int'(w_idx) < KK) begin
            wt[w_ch][w_idx] <= w_data;
        end
    end

    // Per-row partial sums and final shift / ReLU / saturate.
    always_comb begin
        tot    = '0;
        sh     = '0;
        out_nx = '0;
        for (int c = 0; c < OUT_CH; c++) begin
            for (int r = 0; r < K; r++) begin
                rs_nx[c][r] = '0;
                for (int k = 0; k < K; k++) begin
                    rs_nx[c][r] = rs_nx[c][r]
                                + ACC_BIT'(prod[c][r*K+k]);
                end
            end
            tot = '0;
            for (int r = 0; r < K; r++) begin
                tot = tot + rs[c][r];
            end
            sh = tot >>> SHIFT;
            out_nx[c*OUT_BIT +: OUT_BIT] =
                OUT_BIT'(sat_signed(64'(sh), OUT_BIT, rpipe[LAT-2]));
        end
    end

    // Products, row sums, output register and the valid delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            relu_w   <= 1'b0;
            vpipe    <= '0;
            lpipe    <= '0;
            rpipe    <= '0;
            conv_out <= '0;
            for (int c = 0; c < OUT_CH; c++) begin
                for (int t = 0; t < KK; t++) prod[c][t] <= '0;
                for (int r = 0; r < K; r++) rs[c][r] <= '0;
            end
        end else begin
            if (in_valid) relu_w <= relu_en;
            vpipe <= {vpipe[LAT-2:0], win_valid};
            lpipe <= {lpipe[LAT-2:0], last_win};
            rpipe <= {rpipe[LAT-2:0], relu_w};
            for (int c = 0; c < OUT_CH; c++) begin
                for (int t = 0; t < KK; t++) begin
                    prod[c][t] <= PB'($signed({1'b0,
                                  window[t*DATA_BIT +: DATA_BIT]}))
                                * PB'(wt[c][t]);
                end
                for (int r = 0; r < K; r++) rs[c][r] <= rs_nx[c][r];
            end
            if (vpipe[LAT-2]) conv_out <= out_nx;
        end
    end

endmodule
